// File: rtl/nios_system_mem_reader_pkg.sv
// Shared types and default widths for the on-chip memory reader.
package nios_system_mem_reader_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/nios_system_mem_reader_fifo.sv
// Small output buffer for the memory reader: flop storage, output muxed from
// flops only (no path from the write side), occupancy exposed for credit checks.
module nios_system_mem_reader_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [AW:0]                  count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en_i)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset, so the head word reads as zero afterwards.
  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/nios_system_onchip_mem_reader.sv
// Streams a block of on-chip memory words out through a credit-controlled FIFO.
// Optional running sum of streamed beats: define ONCHIP_MEM_READER_CSUM_EN.
module nios_system_onchip_mem_reader
  import nios_system_mem_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_last
`ifdef ONCHIP_MEM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0]     csum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W:0]     beats_q, beats_d;
  logic                inflight_q;
  logic                done_q, done_d;
  logic                rd_issue;
  logic                beat;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         credit;

  // Words already buffered plus the one read still in the memory pipeline.
  assign credit = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign beat   = st_valid & st_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = base_addr;
            rem_d   = length;
            beats_d = length;
            state_d = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rem_q != '0 && credit < (CW+1)'(FIFO_DEPTH)) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1))
            state_d = ST_DRAIN;
        end
      end
      default: ;
    endcase
    if (beat) begin
      beats_d = beats_q - 1'b1;
      if (beats_q == (ADDR_W+1)'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      inflight_q <= rd_issue;
      done_q     <= done_d;
    end
  end

  nios_system_mem_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (inflight_q),
    .wr_data_i (mem_readdata),
    .rd_en_i   (beat),
    .rd_data_o (st_data),
    .valid_o   (st_valid),
    .count_o   (fifo_count)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = rd_issue;
  assign mem_write      = 1'b0;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = '1;
  assign st_last        = st_valid && (beats_q == (ADDR_W+1)'(1));

`ifdef ONCHIP_MEM_READER_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum_q <= '0;
    else if (state_q == ST_IDLE && start)
      csum_q <= '0;
    else if (beat)
      csum_q <= csum_q + st_data;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_nios_system_onchip_mem_reader.sv
// Randomized bench for the memory reader against a queue-free arithmetic model:
// beat k of a transfer must carry mem[(base+k) mod 2^ADDR_W].
module tb_nios_system_onchip_mem_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MSIZE = 1 << AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     length;
  logic            busy, done;
  logic [AW-1:0]   mem_address;
  logic            mem_chipselect, mem_write, mem_clken;
  logic [DW/8-1:0] mem_byteenable;
  logic [DW-1:0]   mem_readdata;
  logic [DW-1:0]   st_data;
  logic            st_valid, st_ready, st_last;
`ifdef ONCHIP_MEM_READER_CSUM_EN
  logic [DW-1:0]   csum;
`endif

  logic [DW-1:0]   mem_arr [MSIZE];
  int              n_chk = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  nios_system_onchip_mem_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_last        (st_last)
`ifdef ONCHIP_MEM_READER_CSUM_EN
    ,
    .csum           (csum)
`endif
  );

  // Synchronous-read memory; garbage when not selected so mistimed captures show up.
  always @(posedge clk)
    mem_readdata <= mem_chipselect ? mem_arr[mem_address] : $urandom();

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = stalled for 10 cycles then ready.
  // abort_at > 0: assert reset right after that many beats have been seen.
  // poke: fire a stray start while busy.
  task automatic do_xfer(input int b, input int n, input int mode, input int abort_at, input bit poke);
    int          cycles, beats, reads;
    bit          prev_final, finished;
    logic [DW-1:0] exp_sum;
    @(negedge clk);
    base_addr = AW'(b);
    length    = (AW+1)'(n);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom());
    length    = (AW+1)'($urandom_range(1, 7));
    if (n == 0) begin
      chk("zl_done", done, 1);
      chk("zl_busy", busy, 0);
      chk("zl_cs", mem_chipselect, 0);
      @(negedge clk);
      chk("zl_done_drop", done, 0);
      chk("zl_cs2", mem_chipselect, 0);
      return;
    end
    cycles = 0; beats = 0; reads = 0; prev_final = 0; finished = 0; exp_sum = '0;
    while (cycles < 3000) begin
      st_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (cycles >= 10) : ($urandom_range(0, 3) != 0);
      start    = poke && (cycles == 3);
      chk("done", done, prev_final);
      chk("busy", busy, !prev_final);
      if (prev_final) begin
        finished = 1;
        break;
      end
      if (mode == 2 && cycles == 9) begin
        chk("stall_reads", reads, (n < DEPTH) ? n : DEPTH);
        chk("stall_valid", st_valid, 1);
      end
      if (mem_chipselect) begin
        chk("addr", mem_address, (b + reads) % MSIZE);
        chk("credit", (reads - beats) < DEPTH, 1);
        chk("overread", reads < n, 1);
        reads++;
      end
      if (st_valid && st_ready) begin
        chk("data", st_data, mem_arr[(b + beats) % MSIZE]);
        chk("last", st_last, beats == n - 1);
        if (mode == 0) chk("lat", cycles, beats + 2);
        exp_sum = exp_sum + mem_arr[(b + beats) % MSIZE];
        beats++;
        prev_final = (beats == n);
        if (abort_at > 0 && beats == abort_at) begin
          start = 1'b0;
          reset = 1'b1;
          #1;
          chk("abort_busy", busy, 0);
          chk("abort_valid", st_valid, 0);
          chk("abort_last", st_last, 0);
          chk("abort_cs", mem_chipselect, 0);
          chk("abort_addr", mem_address, 0);
          chk("abort_data", st_data, 0);
          @(negedge clk);
          reset = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
            chk("abort_idle", busy, 0);
          end
          return;
        end
      end else if (st_valid) begin
        chk("last_hold", st_last, beats == n - 1);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("finished", finished, 1);
    chk("beats", beats, n);
    chk("reads", reads, n);
`ifdef ONCHIP_MEM_READER_CSUM_EN
    chk("csum", csum, exp_sum);
`endif
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b0;
    for (int i = 0; i < MSIZE; i++) mem_arr[i] = DW'(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_valid", st_valid, 0);
    chk("rst_last", st_last, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", st_data, 0);
    chk("tie_write", mem_write, 0);
    chk("tie_clken", mem_clken, 1);
    chk("tie_be", mem_byteenable, 4'hF);
    @(negedge clk);
    reset = 1'b0;

    do_xfer(32'h010, 4, 0, 0, 0);
    do_xfer(32'h3FE, 4, 0, 0, 0);
    do_xfer(0, 0, 0, 0, 0);
    do_xfer(32'h100, 8, 2, 0, 0);
    do_xfer(32'h200, 16, 0, 3, 0);
    do_xfer(32'h040, 2, 0, 0, 0);
    do_xfer(32'h080, 12, 1, 0, 1);

`ifdef ONCHIP_MEM_READER_CSUM_EN
    mem_arr[32'h20] = 32'hFFFF_FFFF;
    mem_arr[32'h21] = 32'h0000_0002;
    do_xfer(32'h020, 2, 0, 0, 0);
    chk("csum_wrap", csum, 32'h0000_0001);
`endif

    for (int i = 0; i < MSIZE; i++) mem_arr[i] = $urandom();
    for (int k = 0; k < 14; k++) begin
      int b, n, m;
      b = $urandom_range(0, MSIZE - 1);
      n = (k == 0) ? MSIZE : $urandom_range(0, 24);
      m = $urandom_range(0, 2);
      do_xfer(b, n, m, 0, n >= 8);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
